// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, almost-full/empty flags and synchronous flush.
// Optional sticky overflow/underflow ports are enabled by defining SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl #(
   parameter int WIDTH         = 32,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   localparam int PTR_WIDTH    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic               rd_en,
   output logic [WIDTH-1:0]   rd_data,
   output logic               rd_valid,
   output logic               full,
   output logic               empty,
   output logic               almost_full,
   output logic               almost_empty,
   output logic [PTR_WIDTH:0] count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic               overflow,
   output logic               underflow
`endif
);

   localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0] count_q, count_d;
   logic [WIDTH-1:0]   rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic               wr_acc, rd_acc;

   // Flags come from the registered pointers/count only, never from the request inputs.
   assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                  (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign almost_full  = (count_q >= AFULL_THRESH[PTR_WIDTH:0]);
   assign almost_empty = (count_q <= AEMPTY_THRESH[PTR_WIDTH:0]);
   assign count    = count_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

   assign wr_acc = wr_en & ~full & ~flush;
   assign rd_acc = rd_en & ~empty & ~flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem[rd_ptr_q[PTR_WIDTH-1:0]];
            rd_valid_d = 1'b1;
         end
         if (wr_acc && !rd_acc)      count_d = count_q + PTR_ONE;
         else if (rd_acc && !wr_acc) count_d = count_q - PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Storage has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_data;
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q | (wr_en & full);
      underflow_d = underflow_q | (rd_en & empty);
      if (flush) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule
